lsu_mem_ctrl: RTL

Load/store controller between the core's memory stage and the byte-array `memory` block. It accepts one load or store request at a time and checks alignment and range. It drives `memory`'s `w_enb`/`r_enb`/`addr`/`w_data` and extracts and sign-extends load data from `r_data`. Because `memory` always writes four bytes, `sb`/`sh` are done as a read-modify-write sequence.

---
 rtl/lsu_mem_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the core memory stage and the
// byte-array memory block. It handles one request at a time, rejects
// misaligned, out-of-range or illegal requests, formats load data, and turns
// sb/sh into a read-modify-write because the memory always writes a full word.
module lsu_mem_ctrl #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_w_enb,
    output logic        mem_r_enb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Highest byte address that still leaves room for a full word access.
    localparam logic [31:0] MAX_ADDR = 32'((1 << ADDR_BITS) - 4);

    state_t      state;
    state_t      next_state;

    // The request direction is carried by the state itself, so only
    // funct3, address and store data need to be kept after accept.
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] merged;

    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_bad;
    logic [31:0] load_fmt;
    logic [31:0] merge_word;

    assign accept = req_valid && req_ready;

    // Classify the incoming request so the route can be chosen at accept.
    always_comb begin
        illegal      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = (req_addr > MAX_ADDR);
        if (req_we) begin
            illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        case (req_funct3)
            F3_W:        misaligned = (req_addr[1:0] != 2'b00);
            F3_H, F3_HU: misaligned = req_addr[0];
            default:     misaligned = 1'b0;
        endcase
        req_bad = illegal || misaligned || out_of_range;
    end

    // Extract and sign/zero-extend the addressed byte, half or word.
    always_comb begin
        load_fmt = mem_r_data;
        case (lat_funct3)
            F3_B:    load_fmt = {{24{mem_r_data[7]}}, mem_r_data[7:0]};
            F3_H:    load_fmt = {{16{mem_r_data[15]}}, mem_r_data[15:0]};
            F3_BU:   load_fmt = {24'h0, mem_r_data[7:0]};
            F3_HU:   load_fmt = {16'h0, mem_r_data[15:0]};
            default: load_fmt = mem_r_data;
        endcase
    end

    // Splice the new byte or half into the word read back from memory.
    always_comb begin
        if (lat_funct3 == F3_B) begin
            merge_word = {mem_r_data[31:8], lat_wdata[7:0]};
        end else begin
            merge_word = {mem_r_data[31:16], lat_wdata[15:0]};
        end
    end

    // State register; reset drops straight back to IDLE, aborting any request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the memory/handshake outputs for each state.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_w_enb  = 1'b0;
        mem_r_enb  = 1'b0;
        mem_addr   = 32'h0;
        mem_w_data = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_bad) begin
                        next_state = RESP;
                    end else if (!req_we) begin
                        next_state = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        next_state = STORE;
                    end else begin
                        next_state = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_r_enb  = 1'b1;
                mem_addr   = lat_addr;
                next_state = RESP;
            end
            STORE: begin
                mem_w_enb  = 1'b1;
                mem_addr   = lat_addr;
                mem_w_data = lat_wdata;
                next_state = RESP;
            end
            RMW_RD: begin
                mem_r_enb  = 1'b1;
                mem_addr   = lat_addr;
                next_state = RMW_WR;
            end
            RMW_WR: begin
                mem_w_enb  = 1'b1;
                mem_addr   = lat_addr;
                mem_w_data = merged;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, merged-word and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_funct3 <= 3'b000;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            merged     <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                resp_rdata <= 32'h0;
                resp_err   <= req_bad;
            end
            if (state == LOAD) begin
                resp_rdata <= load_fmt;
            end
            if (state == RMW_RD) begin
                merged <= merge_word;
            end
        end
    end

endmodule
